// File: rtl/wave_fetch_scheduler_if.sv
// rtl/wave_fetch_scheduler_if.sv - wave queue / instruction fetch signals of the fetch scheduler
interface wave_fetch_scheduler_if #(
  parameter int NUM_WF = 8,
  localparam int ID_W = $clog2(NUM_WF)
);
  logic [NUM_WF-1:0] wf_valid;
  logic [NUM_WF-1:0] wf_stop_fetch;
  logic [NUM_WF-1:0] wf_flush;
  logic              fetch_req;
  logic [ID_W-1:0]   fetch_wf_id;
  logic              fetch_gnt;
  logic              fetch_rsp_valid;
  logic [NUM_WF-1:0] q_vtail_incr;
  logic [NUM_WF-1:0] q_wr;
  logic              busy;
  logic              rsp_err;

  modport master (
    input  wf_valid, wf_stop_fetch, wf_flush, fetch_gnt, fetch_rsp_valid,
    output fetch_req, fetch_wf_id, q_vtail_incr, q_wr, busy, rsp_err
  );

  modport slave (
    output wf_valid, wf_stop_fetch, wf_flush, fetch_gnt, fetch_rsp_valid,
    input  fetch_req, fetch_wf_id, q_vtail_incr, q_wr, busy, rsp_err
  );
endinterface

// File: rtl/wave_fetch_scheduler.sv
// rtl/wave_fetch_scheduler.sv - round-robin instruction fetch scheduler, one fetch outstanding
module wave_fetch_scheduler #(
  parameter int NUM_WF = 8,
  localparam int ID_W = $clog2(NUM_WF)
) (
  input  logic                  clk,
  input  logic                  rst,
  wave_fetch_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   fetch_wf_id, fetch_wf_id_nxt;
  logic              drop, drop_nxt;
  logic              rsp_err, rsp_err_nxt;

  logic [NUM_WF-1:0] elig;
  logic [NUM_WF-1:0] id_onehot;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic              flush_cur;

  logic              fetch_req_c;
  logic              busy_c;
  logic [NUM_WF-1:0] q_vtail_incr_c;
  logic [NUM_WF-1:0] q_wr_c;

  assign elig      = bus.wf_valid & ~bus.wf_stop_fetch & ~bus.wf_flush;
  assign id_onehot = NUM_WF'(1) << fetch_wf_id;
  assign flush_cur = bus.wf_flush[fetch_wf_id];

  // Search begins just past the last winner; the sum wraps naturally in ID_W bits.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    for (int k = 1; k <= NUM_WF; k++) begin
      if (!win_found && elig[rr_ptr + ID_W'(k)]) begin
        win_found = 1'b1;
        win_id    = rr_ptr + ID_W'(k);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    fetch_wf_id_nxt = fetch_wf_id;
    drop_nxt        = drop;
    rsp_err_nxt     = rsp_err | (bus.fetch_rsp_valid && (state != WAIT_RSP));
    fetch_req_c     = 1'b0;
    busy_c          = 1'b0;
    q_vtail_incr_c  = '0;
    q_wr_c          = '0;

    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (win_found) begin
          fetch_wf_id_nxt = win_id;
          rr_ptr_nxt      = win_id;
          state_nxt       = REQ;
        end
      end
      REQ: begin
        fetch_req_c = 1'b1;
        busy_c      = 1'b1;
        if (flush_cur) drop_nxt = 1'b1;
        if (bus.fetch_gnt) begin
          q_vtail_incr_c = id_onehot;
          state_nxt      = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        busy_c = 1'b1;
        if (flush_cur) drop_nxt = 1'b1;
        if (bus.fetch_rsp_valid) begin
          // A flush arriving together with the response still kills the write.
          if (!drop && !flush_cur) q_wr_c = id_onehot;
          drop_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        drop_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(NUM_WF - 1);
      fetch_wf_id <= '0;
      drop        <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      fetch_wf_id <= fetch_wf_id_nxt;
      drop        <= drop_nxt;
      rsp_err     <= rsp_err_nxt;
    end
  end

  assign bus.fetch_req    = fetch_req_c;
  assign bus.fetch_wf_id  = fetch_wf_id;
  assign bus.q_vtail_incr = q_vtail_incr_c;
  assign bus.q_wr         = q_wr_c;
  assign bus.busy         = busy_c;
  assign bus.rsp_err      = rsp_err;

endmodule

// File: tb/tb_wave_fetch_scheduler.sv
// tb/tb_wave_fetch_scheduler.sv - directed vector bench for wave_fetch_scheduler
module tb_wave_fetch_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wave_fetch_scheduler_if #(.NUM_WF(8)) bus ();

  wave_fetch_scheduler #(.NUM_WF(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_first;
    logic [7:0] valid;
    logic [7:0] stop;
    int         gnt_dly;
    int         rsp_dly;
    logic       flush_wait;
    logic [2:0] exp_id;
    logic       exp_wr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] v, input logic [7:0] s, input int gd,
                     input int rd, input logic fw, input logic [2:0] id, input logic wr);
    vec_t e;
    e.rst_first = r; e.valid = v; e.stop = s; e.gnt_dly = gd; e.rsp_dly = rd;
    e.flush_wait = fw; e.exp_id = id; e.exp_wr = wr;
    vecs.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wf_valid = '0; bus.wf_stop_fetch = '0; bus.wf_flush = '0;
    bus.fetch_gnt = 1'b0; bus.fetch_rsp_valid = 1'b0;
    #1;
    chk("rst_fetch_req", 32'(bus.fetch_req), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_q_wr", 32'(bus.q_wr), 0);
    chk("rst_q_vtail_incr", 32'(bus.q_vtail_incr), 0);
    chk("rst_fetch_wf_id", 32'(bus.fetch_wf_id), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered just after a falling edge with the scheduler in IDLE.
  task automatic do_fetch(input vec_t v);
    logic [7:0] oh;
    oh = 8'h01 << v.exp_id;
    bus.wf_valid = v.valid; bus.wf_stop_fetch = v.stop; bus.wf_flush = '0;
    bus.fetch_gnt = 1'b0; bus.fetch_rsp_valid = 1'b0;
    #1;
    chk("idle_no_req", 32'(bus.fetch_req), 0);
    @(negedge clk); #1;
    chk("req_raised", 32'(bus.fetch_req), 1);
    chk("req_id", 32'(bus.fetch_wf_id), 32'(v.exp_id));
    chk("req_busy", 32'(bus.busy), 1);
    for (int i = 0; i < v.gnt_dly; i++) begin
      chk("vtail_before_gnt", 32'(bus.q_vtail_incr), 0);
      @(negedge clk); #1;
      chk("req_held", 32'(bus.fetch_req), 1);
      chk("req_id_stable", 32'(bus.fetch_wf_id), 32'(v.exp_id));
    end
    bus.fetch_gnt = 1'b1; #1;
    chk("vtail_on_gnt", 32'(bus.q_vtail_incr), 32'(oh));
    @(negedge clk);
    bus.fetch_gnt = 1'b0;
    if (v.flush_wait) bus.wf_flush = oh;
    #1;
    chk("wait_req_low", 32'(bus.fetch_req), 0);
    chk("wait_busy", 32'(bus.busy), 1);
    chk("wait_vtail_low", 32'(bus.q_vtail_incr), 0);
    for (int i = 0; i < v.rsp_dly; i++) begin
      chk("wr_before_rsp", 32'(bus.q_wr), 0);
      @(negedge clk); #1;
    end
    bus.fetch_rsp_valid = 1'b1; #1;
    chk("wr_on_rsp", 32'(bus.q_wr), v.exp_wr ? 32'(oh) : 0);
    @(negedge clk);
    bus.fetch_rsp_valid = 1'b0; bus.wf_flush = '0;
    #1;
    chk("idle_busy_low", 32'(bus.busy), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // single fetch
    add(1, 8'h01, 8'h00, 2, 3, 0, 3'd0, 1);
    // round robin over all slots
    add(1, 8'hFF, 8'h00, 0, 0, 0, 3'd0, 1);
    for (int i = 1; i < 10; i++) add(0, 8'hFF, 8'h00, 0, 0, 0, 3'(i % 8), 1);
    // stop_fetch on slot 1 skips it
    add(1, 8'h0F, 8'h02, 0, 0, 0, 3'd0, 1);
    add(0, 8'h0F, 8'h02, 0, 0, 0, 3'd2, 1);
    add(0, 8'h0F, 8'h02, 0, 1, 0, 3'd3, 1);
    add(0, 8'h0F, 8'h02, 1, 0, 0, 3'd0, 1);
    // flush in flight, then pointer continues from slot 3
    add(1, 8'h08, 8'h00, 1, 2, 1, 3'd3, 0);
    add(0, 8'hFF, 8'h00, 0, 0, 0, 3'd4, 1);

    @(negedge clk);
    foreach (vecs[n]) begin
      if (vecs[n].rst_first) do_reset();
      do_fetch(vecs[n]);
    end

    // flush and stop during REQ keep the request up but drop the response
    do_reset();
    bus.wf_valid = 8'h01;
    @(negedge clk);
    bus.wf_flush = 8'h01; bus.wf_stop_fetch = 8'h01; #1;
    chk("req_held_flush", 32'(bus.fetch_req), 1);
    @(negedge clk);
    bus.wf_flush = 8'h00; #1;
    chk("req_held_after_flush", 32'(bus.fetch_req), 1);
    bus.fetch_gnt = 1'b1; #1;
    chk("vtail_flushed_req", 32'(bus.q_vtail_incr), 32'h01);
    @(negedge clk);
    bus.fetch_gnt = 1'b0; bus.wf_stop_fetch = 8'h00; bus.wf_valid = 8'h00;
    bus.fetch_rsp_valid = 1'b1; #1;
    chk("drop_from_req", 32'(bus.q_wr), 0);
    @(negedge clk);
    bus.fetch_rsp_valid = 1'b0; #1;
    chk("drop_idle_busy", 32'(bus.busy), 0);
    chk("drop_no_err", 32'(bus.rsp_err), 0);

    // grant outside REQ is ignored
    bus.fetch_gnt = 1'b1; #1;
    chk("gnt_idle_vtail", 32'(bus.q_vtail_incr), 0);
    @(negedge clk);
    bus.fetch_gnt = 1'b0; #1;
    chk("gnt_idle_busy", 32'(bus.busy), 0);

    // reset mid-fetch
    do_reset();
    bus.wf_valid = 8'h01;
    @(negedge clk);
    bus.fetch_gnt = 1'b1;
    @(negedge clk);
    bus.fetch_gnt = 1'b0; bus.wf_valid = 8'h00; #1;
    chk("midrst_in_wait", 32'(bus.busy), 1);
    rst = 1'b1; #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_req", 32'(bus.fetch_req), 0);
    chk("midrst_vtail", 32'(bus.q_vtail_incr), 0);
    chk("midrst_id", 32'(bus.fetch_wf_id), 0);
    bus.fetch_rsp_valid = 1'b1; #1;
    chk("midrst_wr_in_rst", 32'(bus.q_wr), 0);
    chk("midrst_err_in_rst", 32'(bus.rsp_err), 0);
    bus.fetch_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.fetch_rsp_valid = 1'b1; #1;
    chk("midrst_wr_after", 32'(bus.q_wr), 0);
    @(negedge clk);
    bus.fetch_rsp_valid = 1'b0; #1;
    chk("midrst_rsp_err", 32'(bus.rsp_err), 1);

    // spurious response in IDLE is sticky until reset
    do_reset();
    bus.fetch_rsp_valid = 1'b1; #1;
    chk("spur_q_wr", 32'(bus.q_wr), 0);
    @(negedge clk);
    bus.fetch_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("spur_rsp_err_sticky", 32'(bus.rsp_err), 1);
    chk("spur_busy", 32'(bus.busy), 0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
